// File: rtl/corner_coord_collector_pkg.sv
// Shared types and constants for the corner coordinate collector.
//   DEF_X_W / DEF_Y_W / DEF_CNT_W : default coordinate and counter widths
//   corner_entry_t                : one FIFO entry {eof, x, y}
//   NO_COORD_X / NO_COORD_Y       : coordinate value carried by an EOF marker
package corner_pkg;

    localparam int DEF_X_W   = 10;
    localparam int DEF_Y_W   = 10;
    localparam int DEF_CNT_W = 12;

    typedef struct packed {
        logic               eof;
        logic [DEF_X_W-1:0] x;
        logic [DEF_Y_W-1:0] y;
    } corner_entry_t;

    localparam logic [DEF_X_W-1:0] NO_COORD_X = '1;
    localparam logic [DEF_Y_W-1:0] NO_COORD_Y = '1;

endpackage

// File: rtl/corner_coord_collector_if.sv
// Valid/ready readout port of the corner coordinate FIFO.
//   out_valid : head entry available (producer -> consumer)
//   out_ready : consumer accepts head entry (consumer -> producer)
//   out_x/y   : head coordinates, all-ones in an EOF marker entry
//   out_eof   : head entry is the last entry of its frame
interface corner_coord_collector_if
    import corner_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
) ();

    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic           out_eof;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_eof,
        output out_ready
    );

endinterface

// File: rtl/corner_coord_collector_sync_fifo.sv
// Generic single-clock FIFO; admission policy belongs to the caller.
//   push/push_data : write one entry (caller guarantees space)
//   pop            : remove head entry; ignored while empty
//   head           : entry at the read pointer, from the registered array
//   level          : occupancy, 0..DEPTH (extra bit separates full from empty)
module corner_sync_fifo
    import corner_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 1 + DEF_X_W + DEF_Y_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             pop_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        pop_ok   = pop && (level_q != '0);
        wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the caller masks the head while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/corner_coord_collector.sv
// Collects raster coordinates of flagged corner pixels into a FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sof_in              : start of frame, qualified by in_valid
//   in_valid, in_corner : pixel strobe and corner flag
//   out_if (master)     : valid/ready readout of {eof, x, y} entries
//   fifo_level          : FIFO occupancy
//   frame_done          : one-cycle pulse after a frame's final pixel
//   frame_corner_count  : corner count of the last completed frame
//   overflow            : sticky, an entry was dropped in this frame
module corner_coord_collector
    import corner_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 464,
    parameter int FIFO_DEPTH   = 64,
    parameter int X_W          = DEF_X_W,
    parameter int Y_W          = DEF_Y_W,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sof_in,
    input  logic                        in_valid,
    input  logic                        in_corner,
    corner_coord_collector_if.master    out_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            frame_corner_count,
    output logic                        overflow
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = 1 + X_W + Y_W;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_HEIGHT - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] RSV_LVL  = LVL_W'(FIFO_DEPTH - 1);

    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic               is_sof, is_final;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               push_req, admit, push_ok, pop;
    logic [ENTRY_W-1:0] entry, head;
    logic [LVL_W-1:0]   level;

    always_comb begin
        is_sof   = in_valid && sof_in;
        // A start-of-frame strobe relocates the current pixel to the origin.
        pix_x    = is_sof ? '0 : x_q;
        pix_y    = is_sof ? '0 : y_q;
        is_final = in_valid && (pix_x == X_LAST) && (pix_y == Y_LAST);

        // Plain corners leave the last slot free so the EOF entry always fits.
        push_req = in_valid && (in_corner || is_final);
        admit    = is_final ? (level < FULL_LVL) : (level < RSV_LVL);
        push_ok  = push_req && admit;
        entry    = (is_final && !in_corner) ? {1'b1, {X_W{1'b1}}, {Y_W{1'b1}}}
                                            : {is_final, pix_x, pix_y};

        x_d = x_q;
        y_d = y_q;
        if (in_valid) begin
            if (pix_x == X_LAST) begin
                x_d = '0;
                y_d = (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                x_d = pix_x + 1'b1;
                y_d = pix_y;
            end
        end

        cnt_d = is_sof ? '0 : cnt_q;
        if (in_valid && in_corner && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end

        frame_done_d = is_final;
        frame_cnt_d  = frame_cnt_q;
        if (is_final) begin
            frame_cnt_d = cnt_d;
            cnt_d       = '0;
        end

        overflow_d = is_sof ? 1'b0 : overflow_q;
        if (push_req && !admit) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    corner_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    assign pop              = out_if.out_valid && out_if.out_ready;
    assign out_if.out_valid = (level != '0);
    // Head data is forced to zero while empty so no stale entry is shown.
    assign out_if.out_eof   = out_if.out_valid ? head[ENTRY_W-1] : 1'b0;
    assign out_if.out_x     = out_if.out_valid ? head[X_W+Y_W-1:Y_W] : '0;
    assign out_if.out_y     = out_if.out_valid ? head[Y_W-1:0] : '0;

    assign fifo_level         = level;
    assign frame_done         = frame_done_q;
    assign frame_corner_count = frame_cnt_q;
    assign overflow           = overflow_q;

endmodule
